// File: rtl/imager_rx_pkg.sv
// ============================================================================
// Module      : imager_rx_pkg
// Description : Shared types for the imager_rx capture path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package imager_rx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    WAIT  = 2'd2,
    FRAME = 2'd3
  } state_t;

  // Per-entry markers; the FIFO word is {tag, data}.
  typedef struct packed {
    logic sof;
    logic eol;
  } entry_tag_t;

  localparam int c_TAG_W = $bits(entry_tag_t);

endpackage

`default_nettype wire

// File: rtl/imager_rx_fifo.sv
// ============================================================================
// Module      : imager_rx_fifo
// Description : Synchronous first-word-fall-through FIFO with flush.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imager_rx_fifo #(
  parameter int WIDTH      = 12,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             drop
);

  localparam int c_DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] c_PTR_ONE = 1;

  logic [WIDTH-1:0]    r_mem [c_DEPTH];
  logic [DEPTH_LOG2:0] r_wr_ptr;
  logic [DEPTH_LOG2:0] r_rd_ptr;
  logic                w_full;
  logic                w_do_pop;
  logic                w_do_push;

  assign empty     = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[DEPTH_LOG2] != r_rd_ptr[DEPTH_LOG2]) &&
                     (r_wr_ptr[DEPTH_LOG2-1:0] == r_rd_ptr[DEPTH_LOG2-1:0]);
  assign w_do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot being written.
  assign w_do_push = push && (!w_full || w_do_pop);
  assign drop      = push && w_full && !w_do_pop;
  assign rdata     = empty ? '0 : r_mem[r_rd_ptr[DEPTH_LOG2-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[DEPTH_LOG2-1:0]] <= wdata;
  end

endmodule

`default_nettype wire

// File: rtl/imager_rx.sv
// ============================================================================
// Module      : imager_rx
// Description : Parallel imager (fv/lv/dat) capture with geometry measurement,
//               error flags and a valid/ready pixel stream with sof/eol.
//               Optional macro IMAGER_RX_CHECKSUM_EN adds a per-frame checksum.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imager_rx
  import imager_rx_pkg::*;
#(
  parameter int DATA_WIDTH      = 10,
  parameter int NUM_ROWS_WIDTH  = 12,
  parameter int NUM_COLS_WIDTH  = 12,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      enable,
  input  logic                      clear_err,
  input  logic                      fv,
  input  logic                      lv,
  input  logic [DATA_WIDTH-1:0]     dat,
  output logic [DATA_WIDTH-1:0]     out_data,
  output logic                      out_sof,
  output logic                      out_eol,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      frame_done,
  output logic [NUM_ROWS_WIDTH-1:0] frame_rows,
  output logic [NUM_COLS_WIDTH-1:0] frame_cols,
  output logic [15:0]               frame_count,
  output logic [31:0]               frame_checksum,
  output logic                      line_err,
  output logic                      overflow_err
);

  localparam int c_FIFO_W = DATA_WIDTH + c_TAG_W;

  state_t                    r_state;
  logic                      r_fv_s1, r_lv_s1, r_fv_d, r_lvq_d;
  logic [DATA_WIDTH-1:0]     r_dat_s1;
  logic [NUM_COLS_WIDTH-1:0] r_col, r_ref_cols;
  logic [NUM_ROWS_WIDTH-1:0] r_row;
  logic                      r_ref_valid, r_need_sof;
  logic                      r_pend_valid, r_pend_sof;
  logic [DATA_WIDTH-1:0]     r_pend_data;

  logic w_lvq, w_fv_rise, w_fv_fall, w_start, w_pix, w_lv_fall, w_end;
  logic w_push, w_drop, w_empty, w_mismatch;
  logic [NUM_COLS_WIDTH-1:0] w_col_base, w_col_inc;
  logic [NUM_ROWS_WIDTH-1:0] w_row_inc;
  logic [c_FIFO_W-1:0]       w_wdata, w_rdata;

  assign w_lvq     = r_fv_s1 && r_lv_s1;
  assign w_fv_rise = r_fv_s1 && !r_fv_d;
  assign w_fv_fall = !r_fv_s1 && r_fv_d;
  assign w_start   = enable && (r_state == WAIT) && w_fv_rise;
  assign w_pix     = enable && w_lvq && ((r_state == FRAME) || w_start);
  // Qualified lv falls also when fv drops mid-line, closing that line.
  assign w_lv_fall = enable && (r_state == FRAME) && r_lvq_d && !w_lvq;
  assign w_end     = enable && (r_state == FRAME) && w_fv_fall;
  assign w_push    = r_pend_valid && (w_pix || w_lv_fall);
  assign w_wdata   = {r_pend_sof, w_lv_fall, r_pend_data};

  assign w_col_base = w_start ? '0 : r_col;
  assign w_col_inc  = (&w_col_base) ? w_col_base : w_col_base + NUM_COLS_WIDTH'(1);
  assign w_row_inc  = (&r_row) ? r_row : r_row + NUM_ROWS_WIDTH'(1);
  assign w_mismatch = w_lv_fall && r_ref_valid && (r_col != r_ref_cols);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fv_s1  <= 1'b0;
      r_lv_s1  <= 1'b0;
      r_dat_s1 <= '0;
      r_fv_d   <= 1'b0;
      r_lvq_d  <= 1'b0;
    end else begin
      r_fv_s1  <= fv;
      r_lv_s1  <= lv;
      r_dat_s1 <= dat;
      r_fv_d   <= r_fv_s1;
      r_lvq_d  <= w_lvq;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_col        <= '0;
      r_row        <= '0;
      r_ref_cols   <= '0;
      r_ref_valid  <= 1'b0;
      r_need_sof   <= 1'b0;
      r_pend_valid <= 1'b0;
      r_pend_sof   <= 1'b0;
      r_pend_data  <= '0;
      frame_done   <= 1'b0;
      frame_rows   <= '0;
      frame_cols   <= '0;
      frame_count  <= '0;
      line_err     <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (!enable) begin
        r_state      <= IDLE;
        r_pend_valid <= 1'b0;
      end else begin
        case (r_state)
          IDLE:    r_state <= ARM;
          ARM:     if (!r_fv_s1) r_state <= WAIT;
          WAIT:    if (w_fv_rise) r_state <= FRAME;
          FRAME:   if (w_fv_fall) r_state <= WAIT;
          default: r_state <= IDLE;
        endcase
      end

      if (w_start) begin
        r_col       <= '0;
        r_row       <= '0;
        r_ref_cols  <= '0;
        r_ref_valid <= 1'b0;
        r_need_sof  <= 1'b1;
      end
      if (w_pix) begin
        r_col        <= w_col_inc;
        r_pend_valid <= 1'b1;
        r_pend_data  <= r_dat_s1;
        r_pend_sof   <= w_start || r_need_sof;
        r_need_sof   <= 1'b0;
      end
      if (w_lv_fall) begin
        r_col        <= '0;
        r_row        <= w_row_inc;
        r_pend_valid <= 1'b0;
        if (!r_ref_valid) begin
          r_ref_valid <= 1'b1;
          r_ref_cols  <= r_col;
        end
      end

      if (w_end) begin
        frame_done  <= 1'b1;
        frame_count <= frame_count + 16'd1;
        frame_rows  <= w_lv_fall ? w_row_inc : r_row;
        if (r_ref_valid)    frame_cols <= r_ref_cols;
        else if (w_lv_fall) frame_cols <= r_col;
        else                frame_cols <= '0;
      end

      if (w_mismatch)     line_err <= 1'b1;
      else if (clear_err) line_err <= 1'b0;
      if (w_drop)         overflow_err <= 1'b1;
      else if (clear_err) overflow_err <= 1'b0;
    end
  end

`ifdef IMAGER_RX_CHECKSUM_EN
  logic [31:0] r_csum_acc;
  logic [31:0] r_csum;
  logic [31:0] w_csum_next;

  assign w_csum_next    = r_csum_acc + (w_push ? 32'(r_pend_data) : 32'd0);
  assign frame_checksum = r_csum;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_csum_acc <= '0;
      r_csum     <= '0;
    end else begin
      r_csum_acc <= w_start ? 32'd0 : w_csum_next;
      if (w_end) r_csum <= w_csum_next;
    end
  end
`else
  assign frame_checksum = '0;
`endif

  imager_rx_fifo #(
    .WIDTH      (c_FIFO_W),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (!enable),
    .push    (w_push),
    .wdata   (w_wdata),
    .pop     (out_ready),
    .rdata   (w_rdata),
    .empty   (w_empty),
    .drop    (w_drop)
  );

  assign out_valid = !w_empty;
  assign out_sof   = w_rdata[c_FIFO_W-1];
  assign out_eol   = w_rdata[c_FIFO_W-2];
  assign out_data  = w_rdata[DATA_WIDTH-1:0];

endmodule

`default_nettype wire

// File: tb/tb_imager_rx.sv
// ============================================================================
// Module      : tb_imager_rx
// Description : Directed self-checking bench for imager_rx.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imager_rx;

  logic        clk = 1'b0;
  logic        reset_n, enable, clear_err, fv, lv, out_ready;
  logic [9:0]  dat;
  logic [9:0]  out_data;
  logic        out_sof, out_eol, out_valid, frame_done, line_err, overflow_err;
  logic [11:0] frame_rows, frame_cols;
  logic [15:0] frame_count;
  logic [31:0] frame_checksum;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  logic [11:0] rxq[$];

  imager_rx dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .clear_err(clear_err),
    .fv(fv), .lv(lv), .dat(dat),
    .out_data(out_data), .out_sof(out_sof), .out_eol(out_eol),
    .out_valid(out_valid), .out_ready(out_ready),
    .frame_done(frame_done), .frame_rows(frame_rows), .frame_cols(frame_cols),
    .frame_count(frame_count), .frame_checksum(frame_checksum),
    .line_err(line_err), .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  // Record every accepted entry and every frame_done cycle.
  always @(posedge clk) begin
    if (reset_n && out_valid && out_ready) rxq.push_back({out_sof, out_eol, out_data});
    if (reset_n && frame_done) done_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive_line(input int n, input int base, input bit konst);
    for (int c = 0; c < n; c++) begin
      lv  = 1'b1;
      dat = konst ? 10'd5 : 10'(base + c);
      tick(1);
    end
    lv  = 1'b0;
    dat = '0;
    tick(2);
  endtask

  task automatic drive_frame(input int rows, input int cols, input int short_row, input bit konst);
    int base;
    base = 0;
    fv = 1'b1;
    tick(2);
    for (int r = 0; r < rows; r++) begin
      drive_line((r == short_row) ? cols - 1 : cols, base, konst);
      base += (r == short_row) ? cols - 1 : cols;
    end
    fv = 1'b0;
    tick(8);
  endtask

  task automatic check_stream(input string tag, input int start, input int n, input int cols);
    int bad;
    logic [11:0] x;
    bad = 0;
    check({tag, "_len"}, rxq.size() - start, n);
    for (int k = 0; k < n && start + k < rxq.size(); k++) begin
      x = {(k == 0), ((k % cols) == cols - 1), 10'(k)};
      if (rxq[start + k] !== x) bad++;
    end
    check({tag, "_content"}, bad, 0);
  endtask

  initial begin
    int q0, d0;
    reset_n = 1'b0; enable = 1'b0; clear_err = 1'b0;
    fv = 1'b0; lv = 1'b0; dat = '0; out_ready = 1'b1;
    tick(3);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_done", frame_done, 0);
    check("rst_count", frame_count, 0);
    check("rst_rows", frame_rows, 0);
    check("rst_errs", {line_err, overflow_err}, 0);
    reset_n = 1'b1;
    enable  = 1'b1;
    tick(4);

    // Basic 8x6 frame
    q0 = rxq.size(); d0 = done_cnt;
    drive_frame(6, 8, -1, 1'b0);
    check_stream("f1", q0, 48, 8);
    check("f1_rows", frame_rows, 6);
    check("f1_cols", frame_cols, 8);
    check("f1_count", frame_count, 1);
    check("f1_done", done_cnt - d0, 1);
    check("f1_errs", {line_err, overflow_err}, 0);

    // Stalled consumer: FIFO overflows
    out_ready = 1'b0;
    q0 = rxq.size();
    drive_frame(6, 8, -1, 1'b0);
    check("ovf_err", overflow_err, 1);
    check("ovf_head_stable", {out_valid, out_sof, out_data}, {1'b1, 1'b1, 10'd0});
    out_ready = 1'b1;
    tick(20);
    check_stream("ovf", q0, 16, 8);
    check("ovf_count", frame_count, 2);
    clear_err = 1'b1; tick(1); clear_err = 1'b0; tick(1);
    check("ovf_clear", overflow_err, 0);

    // Short third line
    q0 = rxq.size(); d0 = done_cnt;
    drive_frame(6, 8, 2, 1'b0);
    check("short_lerr", line_err, 1);
    check("short_done", done_cnt - d0, 1);
    check("short_cols", frame_cols, 8);
    check("short_len", rxq.size() - q0, 47);
    clear_err = 1'b1; tick(1); clear_err = 1'b0; tick(1);
    check("short_clear", line_err, 0);

    // Constant-5 4x4 frame checksum
    drive_frame(4, 4, -1, 1'b1);
    check("cs_rows", frame_rows, 4);
    check("cs_cols", frame_cols, 4);
`ifdef IMAGER_RX_CHECKSUM_EN
    check("cs_sum", frame_checksum, 80);
`else
    check("cs_sum", frame_checksum, 0);
`endif

    // Frame with no active lines
    d0 = done_cnt;
    fv = 1'b1; tick(4); fv = 1'b0; tick(8);
    check("zero_done", done_cnt - d0, 1);
    check("zero_geom", {frame_rows, frame_cols}, 0);
    check("zero_count", frame_count, 5);

    // Enable rises mid-frame: nothing captured from that frame
    enable = 1'b0; tick(3);
    q0 = rxq.size(); d0 = done_cnt;
    fv = 1'b1; tick(2);
    drive_line(8, 0, 1'b0);
    enable = 1'b1;
    for (int r = 1; r < 6; r++) drive_line(8, 8 * r, 1'b0);
    fv = 1'b0; tick(8);
    check("enrise_len", rxq.size() - q0, 0);
    check("enrise_done", done_cnt - d0, 0);
    check("enrise_count", frame_count, 5);
    q0 = rxq.size();
    drive_frame(6, 8, -1, 1'b0);
    check_stream("enrise_next", q0, 48, 8);
    check("enrise_next_count", frame_count, 6);

    // Enable drops mid-frame: flush, no frame_done
    out_ready = 1'b0; d0 = done_cnt;
    fv = 1'b1; tick(2);
    drive_line(8, 0, 1'b0);
    drive_line(8, 8, 1'b0);
    check("endrop_filled", out_valid, 1);
    enable = 1'b0; tick(1);
    check("endrop_flush", out_valid, 0);
    drive_line(8, 16, 1'b0);
    fv = 1'b0; tick(8);
    check("endrop_done", done_cnt - d0, 0);
    check("endrop_count", frame_count, 6);
    enable = 1'b1; out_ready = 1'b1; tick(4);

    // Asynchronous reset mid-line, then a clean frame
    fv = 1'b1; tick(2);
    lv = 1'b1; dat = 10'd3; tick(3);
    reset_n = 1'b0; #1;
    check("arst_outs", {out_valid, frame_done, line_err, overflow_err}, 0);
    check("arst_count", frame_count, 0);
    check("arst_geom", {frame_rows, frame_cols}, 0);
    lv = 1'b0; fv = 1'b0; dat = '0;
    tick(2);
    reset_n = 1'b1;
    tick(4);
    q0 = rxq.size(); d0 = done_cnt;
    drive_frame(6, 8, -1, 1'b0);
    check_stream("arst_next", q0, 48, 8);
    check("arst_next_count", frame_count, 1);
    check("arst_next_rows", frame_rows, 6);
    check("arst_next_done", done_cnt - d0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
